// File: rtl/sobel_window_gen.sv
// Raster-order 3x3 window generator feeding the Sobel magnitude stage.
// Two line buffers plus a two-column shift register build each window; border windows are zeroed.
module sobel_window_gen #(
    parameter int WIDTH  = 1600,
    parameter int HEIGHT = 900,
    parameter int DW     = 8,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_pixel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [9*DW-1:0] out_win,
    output logic [XW-1:0]   out_x,
    output logic [YW-1:0]   out_y,
    output logic            out_border,
    output logic            out_sof,
    output logic            out_eof
);
    typedef enum logic [1:0] {S_FILL = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     ix_q, ix_d, cx_q, cx_d;
    logic [YW-1:0]     iy_q, iy_d, cy_q, cy_d;
    logic [DW-1:0]     lb0_q [WIDTH];
    logic [DW-1:0]     lb1_q [WIDTH];
    logic [3*DW-1:0]   cola_q, colb_q, new_col_s;
    logic [9*DW-1:0]   win_s;
    logic              in_ready_s, in_acc_s, load_s, slot_free_s, border_s;
    logic              in_last_s, c_last_x_s, c_last_y_s;
    logic              ov_q, ob_q, osof_q, oeof_q;
    logic [9*DW-1:0]   owin_q;
    logic [XW-1:0]     ox_q;
    logic [YW-1:0]     oy_q;

    assign slot_free_s = !ov_q || out_ready;
    assign in_acc_s    = in_valid && in_ready_s;
    assign in_last_s   = (ix_q == XW'(WIDTH - 1)) && (iy_q == YW'(HEIGHT - 1));
    assign c_last_x_s  = (cx_q == XW'(WIDTH - 1));
    assign c_last_y_s  = (cy_q == YW'(HEIGHT - 1));
    assign border_s    = (cx_q == '0) || (cy_q == '0) || c_last_x_s || c_last_y_s;
    // Column layout: top (row r-2) in the low bits, incoming row r in the high bits.
    assign new_col_s   = {in_pixel, lb1_q[ix_q], lb0_q[ix_q]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (in_acc_s && (iy_q == YW'(1)) && (ix_q == '0)) state_d = S_RUN;
                     else state_d = S_FILL;
            S_RUN:   if (in_acc_s && in_last_s) state_d = S_FLUSH;
                     else state_d = S_RUN;
            S_FLUSH: if (ov_q && out_ready && oeof_q) state_d = S_FILL;
                     else state_d = S_FLUSH;
            default: state_d = S_FILL;
        endcase
    end

    // Output/handshake decode per state
    always_comb begin
        in_ready_s = 1'b0;
        load_s     = 1'b0;
        case (state_q)
            S_FILL:  in_ready_s = 1'b1;
            S_RUN: begin
                in_ready_s = slot_free_s;
                load_s     = in_acc_s;
            end
            S_FLUSH: load_s = slot_free_s && !(ov_q && oeof_q);
            default: in_ready_s = 1'b0;
        endcase
    end

    // Counter next-state: input position and next centre to emit, both wrap at frame end
    always_comb begin
        ix_d = ix_q;
        iy_d = iy_q;
        cx_d = cx_q;
        cy_d = cy_q;
        if (in_acc_s) begin
            if (ix_q == XW'(WIDTH - 1)) begin
                ix_d = '0;
                iy_d = (iy_q == YW'(HEIGHT - 1)) ? '0 : iy_q + YW'(1);
            end else begin
                ix_d = ix_q + XW'(1);
            end
        end else begin
            ix_d = ix_q;
        end
        if (load_s) begin
            if (c_last_x_s) begin
                cx_d = '0;
                cy_d = c_last_y_s ? '0 : cy_q + YW'(1);
            end else begin
                cx_d = cx_q + XW'(1);
            end
        end else begin
            cx_d = cx_q;
        end
    end

    // Window assembly from the two held columns and the incoming column
    always_comb begin
        win_s = '0;
        for (int r = 0; r < 3; r++) begin
            win_s[(r*3+0)*DW +: DW] = cola_q[r*DW +: DW];
            win_s[(r*3+1)*DW +: DW] = colb_q[r*DW +: DW];
            win_s[(r*3+2)*DW +: DW] = new_col_s[r*DW +: DW];
        end
    end

    // Counters and column shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ix_q   <= '0;
            iy_q   <= '0;
            cx_q   <= '0;
            cy_q   <= '0;
            cola_q <= '0;
            colb_q <= '0;
        end else begin
            ix_q <= ix_d;
            iy_q <= iy_d;
            cx_q <= cx_d;
            cy_q <= cy_d;
            if (in_acc_s) begin
                cola_q <= colb_q;
                colb_q <= new_col_s;
            end else begin
                cola_q <= cola_q;
                colb_q <= colb_q;
            end
        end
    end

    // Line buffers: contents need no reset
    always_ff @(posedge clk) begin
        if (in_acc_s) begin
            lb0_q[ix_q] <= lb1_q[ix_q];
            lb1_q[ix_q] <= in_pixel;
        end
    end

    // Output register: load a new window, drop valid on accept, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q   <= 1'b0;
            owin_q <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            ob_q   <= 1'b0;
            osof_q <= 1'b0;
            oeof_q <= 1'b0;
        end else if (load_s) begin
            ov_q   <= 1'b1;
            owin_q <= border_s ? '0 : win_s;
            ox_q   <= cx_q;
            oy_q   <= cy_q;
            ob_q   <= border_s;
            osof_q <= (cx_q == '0) && (cy_q == '0);
            oeof_q <= c_last_x_s && c_last_y_s;
        end else if (out_ready) begin
            ov_q <= 1'b0;
        end else begin
            ov_q <= ov_q;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = ov_q;
    assign out_win    = owin_q;
    assign out_x      = ox_q;
    assign out_y      = oy_q;
    assign out_border = ob_q;
    assign out_sof    = osof_q;
    assign out_eof    = oeof_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 frame: ramp, backpressure, back-to-back and mid-frame reset.
module tb_sobel_window_gen;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    typedef struct {
        int          x;
        int          y;
        bit          border;
        bit          sof;
        bit          eof;
        logic [71:0] win;
    } win_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pixel;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_win;
    logic [2:0]  out_x;
    logic [1:0]  out_y;
    logic        out_border;
    logic        out_sof;
    logic        out_eof;

    int   total = 0;
    int   bad   = 0;
    win_t exp_tbl [NPIX];
    win_t got [$];
    logic [3:0] rpat = 4'b1001;

    sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win), .out_x(out_x),
        .out_y(out_y), .out_border(out_border), .out_sof(out_sof), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] pix(input int base, input int r, input int c);
        return 8'((base + r * W + c) & 255);
    endfunction

    function automatic logic [79:0] meta(input win_t w);
        return {72'(0), 3'(w.x), 2'(w.y), w.border, w.sof, w.eof};
    endfunction

    task automatic build_table(input int base);
        for (int k = 0; k < NPIX; k++) begin
            exp_tbl[k].x      = k % W;
            exp_tbl[k].y      = k / W;
            exp_tbl[k].border = (exp_tbl[k].x == 0) || (exp_tbl[k].y == 0) ||
                                (exp_tbl[k].x == W - 1) || (exp_tbl[k].y == H - 1);
            exp_tbl[k].sof    = (k == 0);
            exp_tbl[k].eof    = (k == NPIX - 1);
            exp_tbl[k].win    = '0;
            if (!exp_tbl[k].border) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        exp_tbl[k].win[(r*3+c)*8 +: 8] =
                            pix(base, exp_tbl[k].y - 1 + r, exp_tbl[k].x - 1 + c);
            end
        end
    endtask

    task automatic run_frame(input int base, input bit tgl, input bit chk_lat);
        int          sent = 0;
        int          cyc = 0;
        bit          done = 0;
        bit          stalled = 0;
        bit          ia, oa;
        logic [79:0] held = '0;
        logic [79:0] cur;
        win_t        rec;
        got.delete();
        while (!done && cyc < 400) begin
            in_valid  = (sent < NPIX);
            in_pixel  = pix(base, sent / W, sent % W);
            out_ready = tgl ? rpat[cyc % 4] : 1'b1;
            @(negedge clk);
            cur = {out_win, out_x, out_y, out_border, out_sof, out_eof};
            if (cyc == 0) chk("ready_at_frame_start", 80'(in_ready), 80'(1));
            if (stalled) chk("hold_stable", cur, held);
            if (out_valid && !out_ready) chk("ready_low_in_stall", 80'(in_ready), 80'(0));
            if (chk_lat && sent == 6) chk("no_out_before_in6", 80'(out_valid), 80'(0));
            if (chk_lat && sent == 7) chk("first_out_after_in6", 80'({out_valid, out_sof}), 80'(2'b11));
            stalled = out_valid && !out_ready;
            held    = cur;
            ia      = in_valid && in_ready;
            oa      = out_valid && out_ready;
            rec.x = int'(out_x); rec.y = int'(out_y); rec.border = out_border;
            rec.sof = out_sof; rec.eof = out_eof; rec.win = out_win;
            @(posedge clk);
            if (ia) sent++;
            if (oa) begin
                got.push_back(rec);
                if (rec.eof) done = 1;
            end
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (!done) chk("frame_timeout", 80'(0), 80'(1));
    endtask

    task automatic verify_frame(input string tag);
        int nb = 0;
        chk({tag, "_win_count"}, 80'(got.size()), 80'(NPIX));
        if (got.size() == NPIX) begin
            for (int k = 0; k < NPIX; k++) begin
                chk($sformatf("%s_meta_%0d", tag, k), meta(got[k]), meta(exp_tbl[k]));
                chk($sformatf("%s_win_%0d", tag, k), 80'(got[k].win), 80'(exp_tbl[k].win));
                if (got[k].border) nb++;
            end
            chk({tag, "_border_count"}, 80'(nb), 80'(14));
        end
    endtask

    initial begin
        logic [71:0] hand11;
        hand11   = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_pixel = 8'd0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("reset_state", {out_valid, out_win, out_x, out_y, out_border, out_sof, out_eof, in_ready},
            {1'b0, 72'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean ramp frame
        build_table(0);
        run_frame(0, 1'b0, 1'b1);
        verify_frame("ramp");
        if (got.size() == NPIX) chk("hand_centre_1_1", 80'(got[6].win), 80'(hand11));

        // Same ramp under 1-0-0-1 backpressure
        run_frame(0, 1'b1, 1'b0);
        verify_frame("stall");

        // Back-to-back frame with a different base
        build_table(100);
        run_frame(100, 1'b0, 1'b0);
        verify_frame("b2b");

        // Reset after nine pixels, then a clean frame
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_pixel = 8'(200 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("mid_reset_state", {out_valid, out_win, out_x, out_y, out_border, out_sof, out_eof, in_ready},
            {1'b0, 72'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        build_table(0);
        run_frame(0, 1'b0, 1'b1);
        verify_frame("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
